// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the pipeline branch/flag logic: branch kinds,
// ARM condition codes, branch_flag_ctrl FSM states and NZCV bit positions.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_CBZ  = 2'b10,
    BR_COND = 2'b11
  } br_type_t;

  typedef logic [3:0] cond_t;

  localparam cond_t COND_EQ = 4'b0000;
  localparam cond_t COND_NE = 4'b0001;
  localparam cond_t COND_HS = 4'b0010;
  localparam cond_t COND_LO = 4'b0011;
  localparam cond_t COND_MI = 4'b0100;
  localparam cond_t COND_PL = 4'b0101;
  localparam cond_t COND_VS = 4'b0110;
  localparam cond_t COND_VC = 4'b0111;
  localparam cond_t COND_HI = 4'b1000;
  localparam cond_t COND_LS = 4'b1001;
  localparam cond_t COND_GE = 4'b1010;
  localparam cond_t COND_LT = 4'b1011;
  localparam cond_t COND_GT = 4'b1100;
  localparam cond_t COND_LE = 4'b1101;
  localparam cond_t COND_AL = 4'b1110;
  localparam cond_t COND_NV = 4'b1111;

  typedef enum logic {
    IDLE      = 1'b0,
    FLAG_WAIT = 1'b1
  } bfc_state_t;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against an NZCV value.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = nzcv[NZCV_N];
  assign z_s = nzcv[NZCV_Z];
  assign c_s = nzcv[NZCV_C];
  assign v_s = nzcv[NZCV_V];

  // Decode the condition field into a pass/fail on the supplied flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_HS: pass = c_s;
      COND_LO: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~(c_s & ~z_s);
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = ~(~z_s & (n_s == v_s));
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_flag_ctrl.sv
// NZCV owner and ID-stage branch resolver. Captures ALU flags at the end of
// EX and resolves B / CBZ / B.cond in ID, adding a single interlock cycle
// when a B.cond would need flags that are still being produced in EX.
module branch_flag_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_setflags,
  input  logic       alu_neg,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_ovf,
  input  logic       id_valid,
  input  logic [1:0] id_br_type,
  input  logic [3:0] id_cond,
  input  logic       id_rt_zero,
  output logic       stall,
  output logic       take_branch,
  output logic [3:0] flags
);

  bfc_state_t state_q;
  bfc_state_t state_d;
  logic [3:0] nzcv_q;
  logic       flag_wr_s;
  logic       cond_pass_s;
  logic       stall_s;
  logic       take_s;
  br_type_t   br_s;

  // A bubble in EX never writes flags, whatever ex_setflags says.
  assign flag_wr_s = ex_valid & ex_setflags;
  assign br_s      = br_type_t'(id_br_type);

  cond_eval u_cond_eval (
    .cond (id_cond),
    .nzcv (nzcv_q),
    .pass (cond_pass_s)
  );

  // Branch decision and next state; outputs are forced low while reset is
  // held so no PC redirect escapes during a mid-operation reset.
  always_comb begin
    stall_s = 1'b0;
    take_s  = 1'b0;
    state_d = state_q;
    if (reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (id_valid) begin
            case (br_s)
              BR_B:   take_s = 1'b1;
              BR_CBZ: take_s = id_rt_zero;
              BR_COND: begin
                if (flag_wr_s) begin
                  // Zero tree is too deep to feed the ID compare this cycle.
                  stall_s = 1'b1;
                  state_d = FLAG_WAIT;
                end else begin
                  take_s = cond_pass_s;
                end
              end
              default: take_s = 1'b0;
            endcase
          end else begin
            take_s = 1'b0;
          end
        end
        FLAG_WAIT: begin
          // Flags are now registered; an external flush (id_valid low)
          // simply drops the held branch.
          state_d = IDLE;
          if (id_valid && (br_s == BR_COND)) begin
            take_s = cond_pass_s;
          end else begin
            take_s = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and architectural NZCV registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      nzcv_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (flag_wr_s) begin
        nzcv_q <= {alu_neg, alu_zero, alu_carry, alu_ovf};
      end
    end
  end

  assign stall       = stall_s;
  assign take_branch = take_s;
  assign flags       = nzcv_q;

endmodule
